twiddle_rot: RTL and testbench
==============================

TWIDDLE_ROT -- requirements
Module: twiddle_rot

Interface
REQ-001 SHALL have parameter N, default 3, meaning sample width W = 2**N bits (two's complement).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, input sample present.
REQ-005 SHALL have port in_ready, output, 1, block accepts an input this cycle.
REQ-006 SHALL have port in_re, input, W, real part of the input sample.
REQ-007 SHALL have port in_im, input, W, imaginary part of the input sample.
REQ-008 SHALL have port k, input, 2, twiddle index selecting W8^k = exp(-j*pi*k/4).
REQ-009 SHALL have port out_valid, output, 1, output sample present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the output this cycle.
REQ-011 SHALL have port out_re, output, W, real part of the rotated sample.
REQ-012 SHALL have port out_im, output, W, imaginary part of the rotated sample.

Function
REQ-013 SHALL transfer an input when in_valid && in_ready on a rising edge, and an output when out_valid && out_ready on a rising edge.
REQ-014 SHALL implement a 2-stage registered pipeline: S1 (pre-add/negate, k registered), S2 (scale/select); minimum latency is 2 cycles from input transfer to out_valid.
REQ-015 SHALL, in S1, compute p = re + im and q = im - re, modulo 2^W (wrap, no saturation), and register re, im, p, q, k and a valid bit.
REQ-016 SHALL define scale(x) = (x>>>1) + (x>>>3) + (x>>>4) + (x>>>6), each shift arithmetic, sum modulo 2^W (approximation of x/sqrt(2), factor 0.703125).
REQ-017 SHALL, in S2, produce: k=0 -> (re, im); k=1 -> (scale(p), scale(q)); k=2 -> (im, -re); k=3 -> (scale(q), -scale(p)); negation modulo 2^W (-(-2^(W-1)) = -2^(W-1)).
REQ-018 SHALL drive out_re/out_im/out_valid directly from S2 registers (no combinational path from inputs to outputs).
REQ-019 SHALL advance S2 when S2 is empty or out_ready is high; SHALL advance S1 into S2 under the same condition.
REQ-020 SHALL set in_ready = !S1.valid || (S2 advancing); in_ready SHALL NOT depend on in_valid.
REQ-021 SHALL hold S2 outputs stable while out_valid && !out_ready (no data change, no drop).
REQ-022 SHALL sustain one transfer per cycle when out_ready is held high, with no bubbles.
REQ-023 SHALL preserve order; every accepted input produces exactly one output.
REQ-024 SHALL, on simultaneous output consumption and input acceptance with both stages full, shift S1->S2 and load S1 in the same cycle.
REQ-025 SHALL clear S1/S2 valid bits when a stage empties (advance with no new data behind it).

Reset
REQ-026 SHALL, while rst is low, asynchronously clear all valid bits and all data/k registers to 0: out_valid=0, out_re=0, out_im=0.
REQ-027 SHALL drive in_ready=1 during and after reset (both stages empty).
REQ-028 SHALL discard in-flight samples when reset asserts mid-operation; no output for them after release.
REQ-029 SHALL first accept input on the first rising edge with rst high.

Verification
REQ-030 SHALL test: W=8, out_ready=1, in (40,24) k=1 -> out (45,-12) two cycles later, out_valid pulse of 1 cycle.
REQ-031 SHALL test: in (40,24) with k=0,2,3 back-to-back -> outputs (40,24), (24,-40), (-12,-45) on 3 consecutive cycles.
REQ-032 SHALL test: out_ready=0 with 3 inputs offered -> exactly 2 accepted, in_ready=0 afterwards, out stable; release -> both delivered in order, third then accepted.
REQ-033 SHALL test: in (-128,-128) k=1 -> p wraps to 0 -> out (0,0); in (-128,0) k=2 -> out (0,-128).
REQ-034 SHALL test: rst low while both stages full -> out_valid=0, out=(0,0) immediately, no stale output after release.
REQ-035 SHALL test: random valid/ready toggling, 1000 samples vs. reference model -> zero mismatches, zero drops/duplicates.

Source files
------------

// File: rtl/twiddle_rot.sv
// -----------------------------------------------------------------------------
// twiddle_rot
// Rotates a complex sample by the radix-8 twiddle factor W8^k = exp(-j*pi*k/4)
// through a two-stage valid/ready pipeline.
//   S1 registers the sample, the pre-sums p = re + im and q = im - re, and k.
//   S2 applies the 1/sqrt(2) approximation (scale) or a swap/negate and holds
//   the result that drives the outputs.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : input sample present
//   in_ready   : block accepts an input this cycle
//   in_re/im   : input sample, W = 2**N bit two's complement
//   k          : twiddle index 0..3
//   out_valid  : output sample present (registered)
//   out_ready  : downstream accepts the output this cycle
//   out_re/im  : rotated sample (registered)
// -----------------------------------------------------------------------------
module twiddle_rot #(
    parameter int N = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] in_re,
    input  logic [2**N-1:0] in_im,
    input  logic [1:0]      k,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2**N-1:0] out_re,
    output logic [2**N-1:0] out_im
);

    localparam int W = 2**N;

    // Twiddle angles in units of -pi/4.
    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_45  = 2'd1,
        ROT_90  = 2'd2,
        ROT_135 = 2'd3
    } rot_e;

    // x * 0.703125 as a sum of arithmetic shifts, wrapping modulo 2^W.
    function automatic logic signed [W-1:0] scale(input logic signed [W-1:0] x);
        return (x >>> 1) + (x >>> 3) + (x >>> 4) + (x >>> 6);
    endfunction

    // Stage 1 registers
    logic                s1_valid_q, s1_valid_d;
    logic signed [W-1:0] s1_re_q,    s1_re_d;
    logic signed [W-1:0] s1_im_q,    s1_im_d;
    logic signed [W-1:0] s1_p_q,     s1_p_d;
    logic signed [W-1:0] s1_q_q,     s1_q_d;
    rot_e                s1_k_q,     s1_k_d;

    // Stage 2 registers
    logic                s2_valid_q, s2_valid_d;
    logic signed [W-1:0] s2_re_q,    s2_re_d;
    logic signed [W-1:0] s2_im_q,    s2_im_d;

    logic                s2_adv;
    logic                in_fire;
    logic signed [W-1:0] rot_re;
    logic signed [W-1:0] rot_im;

    // S2 moves whenever it is empty or its content is being consumed; S1
    // follows it, so a full pipe can drain and refill in the same cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;

    // S2 datapath: select/scale/negate from the S1 registers.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rot_re = s1_re_q;
        rot_im = s1_im_q;
        case (s1_k_q)
            ROT_0: begin
                rot_re = s1_re_q;
                rot_im = s1_im_q;
            end
            ROT_45: begin
                rot_re = scale(s1_p_q);
                rot_im = scale(s1_q_q);
            end
            ROT_90: begin
                rot_re = s1_im_q;
                rot_im = -s1_re_q;
            end
            ROT_135: begin
                rot_re = scale(s1_q_q);
                rot_im = -scale(s1_p_q);
            end
            default: begin
                rot_re = s1_re_q;
                rot_im = s1_im_q;
            end
        endcase
    end

    // Next-state logic for both stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_re_d    = s1_re_q;
        s1_im_d    = s1_im_q;
        s1_p_d     = s1_p_q;
        s1_q_d     = s1_q_q;
        s1_k_d     = s1_k_q;
        s2_valid_d = s2_valid_q;
        s2_re_d    = s2_re_q;
        s2_im_d    = s2_im_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_re_d    = in_re;
            s1_im_d    = in_im;
            s1_p_d     = in_re + in_im;
            s1_q_d     = in_im - in_re;
            s1_k_d     = rot_e'(k);
        end else if (s2_adv) begin
            // S1 content moved on with nothing behind it.
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_re_d = rot_re;
                s2_im_d = rot_im;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours regardless of update order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_p_q     <= '0;
            s1_q_q     <= '0;
            s1_k_q     <= ROT_0;
            s2_valid_q <= 1'b0;
            s2_re_q    <= '0;
            s2_im_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            s1_p_q     <= s1_p_d;
            s1_q_q     <= s1_q_d;
            s1_k_q     <= s1_k_d;
            s2_valid_q <= s2_valid_d;
            s2_re_q    <= s2_re_d;
            s2_im_q    <= s2_im_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_re    = s2_re_q;
    assign out_im    = s2_im_q;

endmodule

// File: tb/tb_twiddle_rot.sv
// -----------------------------------------------------------------------------
// tb_twiddle_rot
// Self-checking bench for twiddle_rot at W = 8. Expected outputs are queued
// when an input is accepted and compared when the DUT delivers an output.
// -----------------------------------------------------------------------------
module tb_twiddle_rot;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_re = '0;
    logic [7:0] in_im = '0;
    logic [1:0] k = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_re;
    logic [7:0] out_im;

    int tests  = 0;
    int failed = 0;
    int received = 0;

    logic [15:0] sb_q[$];

    twiddle_rot #(.N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .k         (k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         re;
        int         im;
        logic [1:0] kk;
        int         exp_re;
        int         exp_im;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] b8(input int x);
        return x[7:0];
    endfunction

    function automatic int wrap8(input int x);
        logic signed [7:0] t;
        t = x[7:0];
        return int'(t);
    endfunction

    function automatic int scale_m(input int x);
        return wrap8((x >>> 1) + (x >>> 3) + (x >>> 4) + (x >>> 6));
    endfunction

    // Reference rotation by W8^k on 8-bit two's complement samples.
    function automatic logic [15:0] model(input logic [7:0] re, input logic [7:0] im,
                                          input logic [1:0] kk);
        int r, i, p, q, orr, oi;
        r = wrap8(int'(re));
        i = wrap8(int'(im));
        p = wrap8(r + i);
        q = wrap8(i - r);
        case (kk)
            2'd0:    begin orr = r;          oi = i;                   end
            2'd1:    begin orr = scale_m(p); oi = scale_m(q);          end
            2'd2:    begin orr = i;          oi = wrap8(-r);           end
            default: begin orr = scale_m(q); oi = wrap8(-scale_m(p));  end
        endcase
        return {b8(orr), b8(oi)};
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // account for input/output transfers that the next rising edge performs.
    task automatic cycle(input bit iv, input logic [7:0] re, input logic [7:0] im,
                         input logic [1:0] kk, input logic [15:0] exp, input bit ordy,
                         output bit acc, output bit ov);
        logic [15:0] e;
        @(negedge clk);
        in_valid  = iv;
        in_re     = re;
        in_im     = im;
        k         = kk;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        ov  = out_valid;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_data", {16'b0, out_re, out_im}, {16'b0, e});
                received++;
            end
        end
        if (acc) sb_q.push_back(exp);
    endtask

    task automatic idle(input bit ordy, output bit ov);
        bit acc;
        cycle(1'b0, 8'd0, 8'd0, 2'd0, 16'd0, ordy, acc, ov);
    endtask

    initial begin
        bit acc, ov;
        bit ovs[16];
        bit accs[16];
        logic [7:0] hold_re, hold_im;
        int n_acc;
        int sent;
        int budget;

        // ---------------- reset state ----------------
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data",  {16'b0, out_re, out_im}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- single sample, k=1: 2-cycle latency, 1-cycle pulse --
        cycle(1'b1, 8'd40, 8'd24, 2'd1, {8'd45, b8(-12)}, 1'b1, acc, ov);
        check("first_accept", {31'b0, acc}, 32'd1);
        check("pulse_c0", {31'b0, ov}, 32'd0);
        idle(1'b1, ov);
        check("pulse_c1", {31'b0, ov}, 32'd0);
        idle(1'b1, ov);
        check("pulse_c2", {31'b0, ov}, 32'd1);
        idle(1'b1, ov);
        check("pulse_c3", {31'b0, ov}, 32'd0);

        // ---------------- table vectors, back-to-back, out_ready=1 ----------
        tbl[0] = '{40,   24,   2'd1, 45,   -12};
        tbl[1] = '{40,   24,   2'd0, 40,   24};
        tbl[2] = '{40,   24,   2'd2, 24,   -40};
        tbl[3] = '{40,   24,   2'd3, -12,  -45};
        tbl[4] = '{-128, -128, 2'd1, 0,    0};
        tbl[5] = '{-128, 0,    2'd2, 0,    -128};
        tbl[6] = '{127,  127,  2'd1, -4,   0};
        tbl[7] = '{100,  -50,  2'd3, 73,   -34};
        tbl[8] = '{-128, 5,    2'd0, -128, 5};
        tbl[9] = '{0,    -128, 2'd2, -128, 0};
        for (int i = 0; i < 13; i++) begin
            if (i < 10)
                cycle(1'b1, b8(tbl[i].re), b8(tbl[i].im), tbl[i].kk,
                      {b8(tbl[i].exp_re), b8(tbl[i].exp_im)}, 1'b1, accs[i], ovs[i]);
            else
                idle(1'b1, ovs[i]);
        end
        for (int i = 0; i < 10; i++) check("tbl_accept", {31'b0, accs[i]}, 32'd1);
        for (int i = 2; i < 12; i++) check("tbl_no_bubble", {31'b0, ovs[i]}, 32'd1);
        check("tbl_drained", {31'b0, ovs[12]}, 32'd0);

        // ---------------- backpressure: 3 offered, 2 accepted ---------------
        n_acc = 0;
        cycle(1'b1, 8'd40, 8'd24, 2'd0, {8'd40, 8'd24}, 1'b0, acc, ov);
        n_acc += int'(acc);
        cycle(1'b1, 8'd40, 8'd24, 2'd2, {8'd24, b8(-40)}, 1'b0, acc, ov);
        n_acc += int'(acc);
        cycle(1'b1, 8'd40, 8'd24, 2'd3, {b8(-12), b8(-45)}, 1'b0, acc, ov);
        n_acc += int'(acc);
        check("bp_accepted", n_acc, 32'd2);
        hold_re = out_re;
        hold_im = out_im;
        check("bp_head", {16'b0, hold_re, hold_im}, {16'b0, 8'd40, 8'd24});
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'd40, 8'd24, 2'd3, {b8(-12), b8(-45)}, 1'b0, acc, ov);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_stable", {15'b0, out_valid, out_re, out_im}, {15'b0, 1'b1, hold_re, hold_im});
        end
        // Release: head delivered and third accepted in the same cycle.
        cycle(1'b1, 8'd40, 8'd24, 2'd3, {b8(-12), b8(-45)}, 1'b1, acc, ov);
        check("bp_third_accept", {31'b0, acc}, 32'd1);
        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            idle(1'b1, ov);
            budget++;
        end
        check("bp_drain", sb_q.size(), 32'd0);

        // ---------------- reset while both stages full ----------------------
        cycle(1'b1, 8'd1, 8'd2, 2'd0, {8'd1, 8'd2}, 1'b0, acc, ov);
        cycle(1'b1, 8'd3, 8'd4, 2'd0, {8'd3, 8'd4}, 1'b0, acc, ov);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_full", {30'b0, out_valid, in_ready}, {30'b0, 1'b1, 1'b0});
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_data",  {16'b0, out_re, out_im}, 32'd0);
        check("mid_rst_in_ready",  {31'b0, in_ready}, 32'd1);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, ov);
            check("post_rst_no_stale", {31'b0, ov}, 32'd0);
        end

        // ---------------- random valid/ready, 1000 samples ------------------
        received = 0;
        sent = 0;
        budget = 0;
        while (sent < 1000 && budget < 20000) begin
            logic [7:0] rr, ri;
            logic [1:0] rk;
            bit iv, ordy;
            rr   = 8'($urandom_range(0, 255));
            ri   = 8'($urandom_range(0, 255));
            rk   = 2'($urandom_range(0, 3));
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            cycle(iv, rr, ri, rk, model(rr, ri, rk), ordy, acc, ov);
            sent += int'(acc);
            budget++;
        end
        check("rand_sent", sent, 32'd1000);
        budget = 0;
        while (sb_q.size() != 0 && budget < 50) begin
            idle(1'b1, ov);
            budget++;
        end
        check("rand_drain", sb_q.size(), 32'd0);
        check("rand_received", received, 32'd1000);
        idle(1'b1, ov);
        check("rand_no_extra", {31'b0, ov}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
